// File: rtl/mouse_tracker.sv
// -----------------------------------------------------------------------------
// mouse_tracker
//
// Assembles 3-byte PS/2 mouse packets (status, dx, dy) and keeps a cursor
// position clamped to [0, X_MAX] x [0, Y_MAX], the last status byte and an
// 8-bit packet counter. A small combinational read port lets the display
// stage fetch any of the four registers.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous, active-high reset
//   rx_data   in   8  byte from the PS/2 receiver
//   rx_valid  in   1  strobe, rx_data valid this cycle (one byte per high cycle)
//   addr      in   2  read select: 0 status, 1 X, 2 Y, 3 packet count
//   data      out  8  selected register (combinational from addr)
//   pkt_done  out  1  one-cycle pulse in the cycle after a packet commits
// -----------------------------------------------------------------------------
module mouse_tracker #(
    parameter int          X_MAX   = 159,
    parameter int          Y_MAX   = 119,
    parameter int          X_INIT  = 80,
    parameter int          Y_INIT  = 60,
    parameter logic [19:0] TIMEOUT = 20'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [1:0] addr,
    output logic [7:0] data,
    output logic       pkt_done
);

    typedef enum logic [1:0] {
        ST_B0 = 2'd0,
        ST_B1 = 2'd1,
        ST_B2 = 2'd2
    } state_t;

    localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
    localparam logic [7:0]         X_INIT_B = 8'(X_INIT);
    localparam logic [7:0]         Y_INIT_B = 8'(Y_INIT);

    // Saturate a signed 11-bit coordinate into [0, vmax]; vmax <= 255 so the
    // result always fits in 8 bits.
    function automatic logic [7:0] clamp_axis(input logic signed [10:0] v,
                                              input logic signed [10:0] vmax);
        logic [7:0] res;
        if (v < 11'sd0) begin
            res = 8'd0;
        end else if (v > vmax) begin
            res = vmax[7:0];
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    state_t      r_state;
    logic [19:0] r_cnt;
    logic [7:0]  r_byte0;
    logic [7:0]  r_dx;
    logic [7:0]  r_status;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_count;
    logic        r_pkt_done;

    state_t      w_state_nxt;
    logic [19:0] w_cnt_nxt;
    logic [19:0] w_cnt_inc;
    logic [7:0]  w_byte0_nxt;
    logic [7:0]  w_dx_nxt;
    logic [7:0]  w_status_nxt;
    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic [7:0]  w_count_nxt;
    logic        w_pkt_done_nxt;

    logic signed [10:0] w_x_ext;
    logic signed [10:0] w_y_ext;
    logic signed [10:0] w_dx_ext;
    logic signed [10:0] w_dy_ext;
    logic signed [10:0] w_x_sum;
    logic signed [10:0] w_y_diff;
    logic [7:0]         w_x_upd;
    logic [7:0]         w_y_upd;

    // Movement arithmetic for the commit cycle: dx comes from the latched
    // byte, dy is the byte arriving now, signs come from the latched status.
    always_comb begin
        w_x_ext   = $signed({3'b000, r_x});
        w_y_ext   = $signed({3'b000, r_y});
        w_dx_ext  = $signed({{3{r_byte0[4]}}, r_dx});
        w_dy_ext  = $signed({{3{r_byte0[5]}}, rx_data});
        w_x_sum   = w_x_ext + w_dx_ext;
        // Screen Y grows downward while mouse dy is positive upward.
        w_y_diff  = w_y_ext - w_dy_ext;
        w_cnt_inc = r_cnt + 20'd1;
        if (r_byte0[6]) begin
            w_x_upd = r_x;
        end else begin
            w_x_upd = clamp_axis(w_x_sum, X_MAX_S);
        end
        if (r_byte0[7]) begin
            w_y_upd = r_y;
        end else begin
            w_y_upd = clamp_axis(w_y_diff, Y_MAX_S);
        end
    end

    // Next-state logic: packet assembly, inter-byte timeout and commit.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_byte0_nxt    = r_byte0;
        w_dx_nxt       = r_dx;
        w_status_nxt   = r_status;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_count_nxt    = r_count;
        w_pkt_done_nxt = 1'b0;
        case (r_state)
            ST_B0: begin
                w_cnt_nxt = 20'd0;
                // Only a byte with bit 3 set can start a packet; anything
                // else is dropped so the stream resynchronises.
                if (rx_valid && rx_data[3]) begin
                    w_byte0_nxt = rx_data;
                    w_state_nxt = ST_B1;
                end else begin
                    w_state_nxt = ST_B0;
                end
            end
            ST_B1: begin
                // A byte arriving on the would-be timeout cycle wins.
                if (rx_valid) begin
                    w_dx_nxt    = rx_data;
                    w_cnt_nxt   = 20'd0;
                    w_state_nxt = ST_B2;
                end else if (w_cnt_inc == TIMEOUT) begin
                    w_cnt_nxt   = 20'd0;
                    w_state_nxt = ST_B0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_B2: begin
                if (rx_valid) begin
                    // All visible registers change together on this edge.
                    w_status_nxt   = r_byte0;
                    w_x_nxt        = w_x_upd;
                    w_y_nxt        = w_y_upd;
                    w_count_nxt    = r_count + 8'd1;
                    w_pkt_done_nxt = 1'b1;
                    w_cnt_nxt      = 20'd0;
                    w_state_nxt    = ST_B0;
                end else if (w_cnt_inc == TIMEOUT) begin
                    w_cnt_nxt   = 20'd0;
                    w_state_nxt = ST_B0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_nxt   = 20'd0;
                w_state_nxt = ST_B0;
            end
        endcase
    end

    // State and register file, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_B0;
            r_cnt      <= 20'd0;
            r_byte0    <= 8'h00;
            r_dx       <= 8'h00;
            r_status   <= 8'h00;
            r_x        <= X_INIT_B;
            r_y        <= Y_INIT_B;
            r_count    <= 8'd0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_byte0    <= w_byte0_nxt;
            r_dx       <= w_dx_nxt;
            r_status   <= w_status_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_count    <= w_count_nxt;
            r_pkt_done <= w_pkt_done_nxt;
        end
    end

    // Zero-latency read port for the display stage.
    always_comb begin
        data = 8'h00;
        case (addr)
            2'd0:    data = r_status;
            2'd1:    data = r_x;
            2'd2:    data = r_y;
            2'd3:    data = r_count;
            default: data = 8'h00;
        endcase
    end

    assign pkt_done = r_pkt_done;

endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 The block SHALL have parameter X_MAX, default 159: maximum X position, inclusive.
REQ-002 The block SHALL have parameter Y_MAX, default 119: maximum Y position, inclusive.
REQ-003 The block SHALL have parameter X_INIT, default 80: X position after reset.
REQ-004 The block SHALL have parameter Y_INIT, default 60: Y position after reset.
REQ-005 The block SHALL have parameter TIMEOUT, default 20'd500000: inter-byte timeout in clk cycles.
REQ-006 Port clk, input, 1 bit: system clock, rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 Port rx_data, input, 8 bits: byte received from the PS/2 receiver.
REQ-009 Port rx_valid, input, 1 bit: single-cycle strobe; rx_data is valid in that cycle.
REQ-010 Port addr, input, 2 bits: register-read select from the display stage.
REQ-011 Port data, output, 8 bits: selected register contents.
REQ-012 Port pkt_done, output, 1 bit: one-cycle pulse after each committed packet.

Function
REQ-013 The block SHALL assemble 3-byte PS/2 mouse packets using states ST_B0, ST_B1 and ST_B2.
- ST_B0 (status byte): on rx_valid with rx_data[3]=1, latch byte0 and go to ST_B1.
- ST_B0: on rx_valid with rx_data[3]=0, discard the byte and stay in ST_B0 (resync).
- ST_B1: on rx_valid, latch dx and go to ST_B2.
- ST_B2: on rx_valid, commit the packet and go to ST_B0.
REQ-014 The block SHALL interpret byte0 as follows:
- bits[2:0]: buttons.
- bit4: X sign.
- bit5: Y sign.
- bit6: X overflow.
- bit7: Y overflow.
REQ-015 Movement SHALL be the 9-bit two's-complement values {sign, byte}, sign-extended to 11-bit signed arithmetic.
REQ-016 On commit, the status register SHALL load byte0 unconditionally.
REQ-017 On commit, X SHALL become clamp(X + dx, 0, X_MAX).
REQ-018 On commit, Y SHALL become clamp(Y - dy, 0, Y_MAX), because screen Y increases downward.
REQ-019 If the X overflow bit is set, X SHALL be unchanged for that packet; likewise Y for the Y overflow bit; the other axis still updates.
REQ-020 Status, X, Y and the packet count SHALL all update on the same clock edge as the third rx_valid; the display stage never sees a partial packet.
REQ-021 The packet count SHALL be 8 bits, increment by 1 per commit, and wrap 255 -> 0.
REQ-022 pkt_done SHALL be registered and high for exactly the one cycle following the commit edge.
REQ-023 The read port SHALL be combinational from addr:
- 0 -> status.
- 1 -> X[7:0].
- 2 -> Y[7:0].
- 3 -> packet count.
REQ-024 There SHALL be no read latency; data changes in the same cycle as addr or the registers change.
REQ-025 In ST_B1 and ST_B2 the timeout counter SHALL increment each cycle without rx_valid and clear on rx_valid; in ST_B0 it is held at 0.
REQ-026 When the timeout counter reaches TIMEOUT, the FSM SHALL return to ST_B0, discard partial bytes and leave all registers unchanged.
REQ-027 If rx_valid coincides with the cycle the counter would reach TIMEOUT, the byte SHALL be accepted and the timeout suppressed.
REQ-028 rx_valid held high for multiple cycles SHALL be treated as one byte per high cycle; no edge detection is performed.
REQ-029 X_MAX and Y_MAX SHALL be at most 255; clamp comparisons use signed 11-bit values, so no wrap-around is possible.

Reset
REQ-030 While rst is high the block SHALL hold:
- state ST_B0, timeout counter 0.
- status 8'h00, X = X_INIT, Y = Y_INIT, packet count 0.
- pkt_done 0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet; the first byte after release is treated as a status byte.
REQ-032 No commit SHALL occur on the cycle rst deasserts.

Verification
REQ-033 Bytes 08, 05, 03 -> X=85, Y=57, status=08, count=1, pkt_done one cycle; addr=1 reads 0x55.
REQ-034 Bytes 38, F6, FE (dx=-10, dy=-2) -> X=70, Y=62; then 09, FF, 00 -> X=159 (clamped), status reads 0x09.
REQ-035 Leading bytes 05, 00 (bit3=0) then 08, 01, 01 -> both leading bytes discarded; exactly one commit: X=81, Y=59.
REQ-036 Byte 08 then an idle gap of TIMEOUT cycles, then 08, 02, 00 -> the first packet is abandoned; single commit with X=82, count=1.
REQ-037 Bytes 48, FF, 04 (X overflow set) -> X stays 80, Y=56, status=48.
REQ-038 rst pulsed after byte 2 of a packet -> all registers at reset values; the next 08, 00, 00 commits with count=1.
